// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity,
// one or two stop bits, internal baud divider. All configuration is captured per frame.
module uart_tx_cfg #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIV_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP_BITS,
    input  logic [DIV_WIDTH-1:0]  BAUD_DIV,
    output logic                  TX_OUT,
    output logic                  Busy,
    output logic                  TX_DONE
);

    localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                state_q, state_d;
    logic [DIV_WIDTH-1:0]  baud_cnt_q, baud_cnt_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [IdxW-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  bit_end;

    // Divider is held at >= 1, so the subtraction never underflows.
    assign bit_end = (baud_cnt_q == div_q - DIV_WIDTH'(1));

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        div_d      = div_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        done_d     = 1'b0;

        if (state_q != StIdle) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + DIV_WIDTH'(1);
        end

        case (state_q)
            StIdle: begin
                if (DATA_VALID) begin
                    state_d    = StStart;
                    baud_cnt_d = '0;
                    data_d     = P_DATA;
                    par_en_d   = PAR_EN;
                    par_bit_d  = (^P_DATA) ^ PAR_TYP;
                    stop2_d    = STOP_BITS;
                    div_d      = (BAUD_DIV == '0) ? DIV_WIDTH'(1) : BAUD_DIV;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_idx_q == IdxW'(DATA_WIDTH - 1)) begin
                        state_d    = par_en_q ? StParity : StStop;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + IdxW'(1);
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d    = StStop;
                    stop_cnt_d = 1'b0;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they appear registered with the state.
        tx_d   = 1'b1;
        busy_d = (state_d != StIdle);
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = data_d[bit_idx_d];
            StParity: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            div_q      <= DIV_WIDTH'(1);
            bit_idx_q  <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign TX_OUT  = tx_q;
    assign Busy    = busy_q;
    assign TX_DONE = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: an 8-bit and a 5-bit instance, frames checked bit by bit
// against hand-written line sequences.
module tb_uart_tx_cfg;

    logic       clk;
    logic       rst;
    logic [7:0] p_data_a;
    logic [4:0] p_data_b;
    logic       dv_a, dv_b;
    logic       par_en, par_typ, stop_bits;
    logic [7:0] baud_div;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;

    int vectors;
    int miscompares;

    uart_tx_cfg #(.DATA_WIDTH(8), .DIV_WIDTH(8)) u_dut_a (
        .CLK(clk), .RST(rst), .P_DATA(p_data_a), .DATA_VALID(dv_a), .PAR_EN(par_en),
        .PAR_TYP(par_typ), .STOP_BITS(stop_bits), .BAUD_DIV(baud_div),
        .TX_OUT(tx_a), .Busy(busy_a), .TX_DONE(done_a)
    );

    uart_tx_cfg #(.DATA_WIDTH(5), .DIV_WIDTH(8)) u_dut_b (
        .CLK(clk), .RST(rst), .P_DATA(p_data_b), .DATA_VALID(dv_b), .PAR_EN(par_en),
        .PAR_TYP(par_typ), .STOP_BITS(stop_bits), .BAUD_DIV(baud_div),
        .TX_OUT(tx_b), .Busy(busy_b), .TX_DONE(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input bit sel, input logic exp_done);
        check({tag, " tx"}, sel ? tx_b : tx_a, 1'b1);
        check({tag, " busy"}, sel ? busy_b : busy_a, 1'b0);
        check({tag, " done"}, sel ? done_b : done_a, exp_done);
    endtask

    // Caller has set configuration and raised the request; the first step is the acceptance edge.
    // At bit 3 the 8-bit instance sees P_DATA changed and, unless held, a stray request pulse.
    task automatic run_frame(input string tag, input string bits, input int d, input bit sel,
                             input bit hold, input logic [7:0] mid);
        step();
        if (!hold) begin
            dv_a = 1'b0;
            dv_b = 1'b0;
        end
        for (int b = 0; b < bits.len(); b++) begin
            for (int c = 0; c < d; c++) begin
                check($sformatf("%s bit%0d cyc%0d tx", tag, b, c), sel ? tx_b : tx_a,
                      logic'(bits.getc(b) == "1"));
                check($sformatf("%s bit%0d cyc%0d busy", tag, b, c), sel ? busy_b : busy_a,
                      1'b1);
                check($sformatf("%s bit%0d cyc%0d done", tag, b, c), sel ? done_b : done_a,
                      1'b0);
                if (b == 3 && c == 0 && !sel) begin
                    p_data_a = mid;
                    if (!hold) dv_a = 1'b1;
                end
                step();
                if (!hold) dv_a = 1'b0;
            end
        end
        check_idle({tag, " end"}, sel, 1'b1);
        if (!hold) begin
            step();
            check_idle({tag, " after"}, sel, 1'b0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        p_data_a    = 8'h00;
        p_data_b    = 5'b00000;
        dv_a        = 1'b1;
        dv_b        = 1'b1;
        par_en      = 1'b0;
        par_typ     = 1'b0;
        stop_bits   = 1'b0;
        baud_div    = 8'd4;

        // Reset dominates a pending request.
        step();
        step();
        check_idle("reset a", 1'b0, 1'b0);
        check_idle("reset b", 1'b1, 1'b0);
        rst  = 1'b0;
        dv_a = 1'b0;
        dv_b = 1'b0;
        step();
        check_idle("idle a", 1'b0, 1'b0);

        // 1: 0xA5, even parity, one stop bit, divide by 4; stray pulse mid-frame.
        par_en = 1'b1; par_typ = 1'b0; stop_bits = 1'b0; baud_div = 8'd4;
        p_data_a = 8'hA5; dv_a = 1'b1;
        run_frame("s1", "01010010101", 4, 1'b0, 1'b0, 8'h00);

        // 2: 0x01, odd parity, two stop bits.
        par_typ = 1'b1; stop_bits = 1'b1;
        p_data_a = 8'h01; dv_a = 1'b1;
        run_frame("s2", "010000000011", 4, 1'b0, 1'b0, 8'hFF);

        // 3: 0xFF, no parity, divider 0 acts as 1.
        par_en = 1'b0; par_typ = 1'b0; stop_bits = 1'b0; baud_div = 8'd0;
        p_data_a = 8'hFF; dv_a = 1'b1;
        run_frame("s3", "0111111111", 1, 1'b0, 1'b0, 8'h00);

        // 4: held request, data changed mid-frame; second frame follows the done cycle.
        baud_div = 8'd2;
        p_data_a = 8'h3C; dv_a = 1'b1;
        run_frame("s4a", "0001111001", 2, 1'b0, 1'b1, 8'hC3);
        run_frame("s4b", "0110000111", 2, 1'b0, 1'b0, 8'hC3);

        // 5: reset while data bit 3 is on the line, then a clean frame.
        par_en = 1'b1; par_typ = 1'b0; stop_bits = 1'b0; baud_div = 8'd4;
        p_data_a = 8'h5A; dv_a = 1'b1;
        step();
        dv_a = 1'b0;
        for (int i = 0; i < 16; i++) step();
        check("s5 bit3 tx", tx_a, 1'b1);
        check("s5 bit3 busy", busy_a, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("s5 rst", 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_idle($sformatf("s5 quiet%0d", i), 1'b0, 1'b0);
        end
        dv_a = 1'b1;
        run_frame("s5b", "00101101001", 4, 1'b0, 1'b0, 8'h5A);

        // 6: 5-bit instance, 10110, even parity, divide by 3.
        par_en = 1'b1; par_typ = 1'b0; stop_bits = 1'b0; baud_div = 8'd3;
        p_data_b = 5'b10110; dv_b = 1'b1;
        run_frame("s6", "00110111", 3, 1'b1, 1'b0, 8'h00);
        check_idle("s6 a quiet", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised successor to the fixed 8-bit UART transmitter. It serialises a DATA_WIDTH-bit word into an asynchronous frame: start bit, data bits LSB first, optional parity bit, and 1 or 2 stop bits. An internal baud divider means the block runs directly on the system clock, with no external bit-rate enable. It adds a one-cycle completion pulse and captures all configuration per frame. It sits between the system controller and the serial pin.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
DIV_WIDTH, 8, width of the BAUD_DIV port (cycles per bit).

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RST  input  1  synchronous, active-high reset.
P_DATA  input  DATA_WIDTH  parallel word to transmit.
DATA_VALID  input  1  request to send P_DATA.
PAR_EN  input  1  1 = parity bit included.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
STOP_BITS  input  1  0 = one stop bit, 1 = two stop bits.
BAUD_DIV  input  DIV_WIDTH  clock cycles per serial bit; 0 is treated as 1.
TX_OUT  output  1  serial line, registered, idles high.
Busy  output  1  high while a frame is in progress.
TX_DONE  output  1  one-cycle pulse when a frame ends.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: TX_OUT=1, Busy=0, TX_DONE=0, state=IDLE, all counters 0.
- RST wins over every other input in the same cycle.
- RST mid-frame: the frame is abandoned. On the next edge the line returns high, Busy=0, and no TX_DONE pulse is issued.
- Acceptance: at an edge where DATA_VALID=1, Busy=0 and RST=0.
  - The block captures P_DATA, PAR_EN, PAR_TYP, STOP_BITS and the effective divider D (max(BAUD_DIV,1)).
  - The block computes the parity bit from the captured word: XOR of all bits, inverted when PAR_TYP=1.
  - Input changes after acceptance have no effect on the frame in flight.
- DATA_VALID while Busy=1 is ignored. It is neither queued nor flagged.
- Latency: TX_OUT drives the start bit (0) and Busy=1 from the edge after acceptance.
- Bit timing: every bit holds for exactly D cycles.
- Frame length: (1 + DATA_WIDTH + PAR_EN + 1 + STOP_BITS) × D cycles with Busy=1.
- State machine:
  - IDLE: TX_OUT=1. On acceptance go to START.
  - START: TX_OUT=0 for D cycles, then go to DATA with bit index 0.
  - DATA: TX_OUT=data[idx] for D cycles, then idx increments. After idx=DATA_WIDTH-1, go to PARITY if PAR_EN=1, otherwise to STOP.
  - PARITY: TX_OUT=parity for D cycles, then go to STOP.
  - STOP: TX_OUT=1 for D cycles per stop bit (one or two bits per captured STOP_BITS), then go to IDLE.
- Counters: a baud counter runs 0..D-1 and wraps, advancing bit/state on its terminal count. The bit index is sized to hold DATA_WIDTH-1.
- End of frame: on the edge leaving STOP, Busy falls and TX_DONE=1 for exactly one cycle. TX_OUT stays 1.
- Back-to-back: DATA_VALID held high is accepted on the first cycle with Busy=0. The next start bit begins one cycle later, so the minimum inter-frame gap is one idle clock beyond the stop bits.
- BAUD_DIV=1 (or 0): one bit per clock. No counter underflow is permitted.
- Outputs are registered. There is no combinational path from any input to TX_OUT, Busy or TX_DONE.

Test Plan:
1. Even parity, one stop bit. DATA_WIDTH=8, BAUD_DIV=4, PAR_EN=1, PAR_TYP=0, STOP_BITS=0, P_DATA=0xA5 pulsed for one cycle.
   - Required: TX_OUT sequence, each bit held 4 cycles: 0,1,0,1,0,0,1,0,1,0,1.
   - Required: Busy high for exactly 44 cycles, then a single TX_DONE pulse.
2. Odd parity, two stop bits. Same as scenario 1 but PAR_TYP=1, STOP_BITS=1, P_DATA=0x01.
   - Required: data bits 1,0,0,0,0,0,0,0; parity 0; two stop bits.
   - Required: frame of 12 bits × 4 = 48 cycles.
3. No parity, minimum divider. PAR_EN=0, BAUD_DIV=0, P_DATA=0xFF.
   - Required: 10-cycle frame 0,1,1,1,1,1,1,1,1,1 at one bit per clock.
   - Required: Busy high for 10 cycles.
4. Held request and ignored input. Hold DATA_VALID=1 with P_DATA=0x3C, then change P_DATA to 0xC3 mid-frame.
   - Required: the first frame carries 0x3C.
   - Required: the second frame (0xC3) starts exactly one cycle after TX_DONE.
   - Required: a DATA_VALID pulse during Busy never alters the frame in flight.
5. Reset mid-frame. Assert RST during the DATA state at bit 3.
   - Required: next edge gives TX_OUT=1, Busy=0, TX_DONE=0.
   - Required: a fresh request after reset produces a complete, correct frame.
6. Parameter variant. Instance with DATA_WIDTH=5, BAUD_DIV=3, PAR_EN=1, even parity, P_DATA=5'b10110.
   - Required: TX_OUT sequence 0,0,1,1,0,1,1,1 (parity 1).
   - Required: 8 × 3 = 24 cycles with Busy high.
